// File: rtl/sort_host.sv
// rtl/sort_host.sv - host controller: stream load, sorter start/done handshake, sorted readback
// Define SORT_CHECK_EN to add a sticky order_err monitor on the readback stream.
module sort_host #(
    parameter int MAX_LEN = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       sort_rdy,
    output logic       sort_start,
    input  logic       sort_done,
    output logic       mem_sel,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wrdata,
    output logic       mem_wren,
    input  logic [7:0] mem_rddata,
    output logic       busy,
    output logic       overflow,
    output logic       order_err
);
    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_WR_SIZE, S_ARM, S_WAIT_RDY,
        S_SORTING, S_RD_ISSUE, S_RD_WAIT, S_OUT_HOLD
    } state_t;

    localparam logic [7:0] LP_MAX = 8'(MAX_LEN);

    state_t     r_state;
    logic       r_in_ready;
    logic [7:0] r_count;
    logic [7:0] r_k;
    logic [7:0] r_out_data;
    logic [1:0] r_cyc;
    logic       r_overflow;

    logic       w_in_hs;
    logic       w_store;
    logic       w_last_k;
    logic       w_done;

    assign w_in_hs  = in_valid && r_in_ready;
    assign w_store  = w_in_hs && (r_count < LP_MAX);
    assign w_last_k = (r_k == r_count);
    // r_cyc counts cycles since the start pulse; ignore sort_rdy until the sorter has had time to drop it
    assign w_done   = (r_state == S_SORTING) && (r_cyc >= 2'd2) && (sort_done || sort_rdy);

    assign in_ready   = r_in_ready;
    assign out_valid  = (r_state == S_OUT_HOLD);
    assign out_last   = (r_state == S_OUT_HOLD) && w_last_k;
    assign out_data   = r_out_data;
    assign sort_start = (r_state == S_WAIT_RDY) && sort_rdy;
    assign mem_sel    = (r_state == S_ARM) || (r_state == S_WAIT_RDY) || (r_state == S_SORTING);
    assign busy       = (r_state != S_IDLE);
    assign overflow   = r_overflow;

    always_comb begin
        mem_wren   = 1'b0;
        mem_addr   = 8'd0;
        mem_wrdata = 8'd0;
        if (w_store) begin
            mem_wren   = 1'b1;
            mem_addr   = r_count + 8'd1;
            mem_wrdata = in_data;
        end else if (r_state == S_WR_SIZE) begin
            mem_wren   = 1'b1;
            mem_wrdata = r_count;
        end else if (r_state == S_RD_ISSUE) begin
            mem_addr   = r_k;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_count    <= 8'd0;
            r_k        <= 8'd0;
            r_out_data <= 8'd0;
            r_cyc      <= 2'd0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_LOAD: begin
                    r_in_ready <= 1'b1;
                    if (w_in_hs) begin
                        if (w_store)
                            r_count <= r_count + 8'd1;
                        // the first byte of a load clears the flag left by the previous load
                        r_overflow <= ((r_state == S_LOAD) && r_overflow) || !w_store;
                        if (in_last) begin
                            r_state    <= S_WR_SIZE;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_state    <= S_LOAD;
                        end
                    end
                end
                S_WR_SIZE: r_state <= S_ARM;
                S_ARM:     r_state <= S_WAIT_RDY;
                S_WAIT_RDY: begin
                    if (sort_rdy) begin
                        r_cyc   <= 2'd1;
                        r_state <= S_SORTING;
                    end
                end
                S_SORTING: begin
                    if (r_cyc != 2'd3)
                        r_cyc <= r_cyc + 2'd1;
                    if (w_done) begin
                        r_k     <= 8'd1;
                        r_state <= S_RD_ISSUE;
                    end
                end
                S_RD_ISSUE: r_state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    r_out_data <= mem_rddata;
                    r_state    <= S_OUT_HOLD;
                end
                S_OUT_HOLD: begin
                    if (out_ready) begin
                        if (w_last_k) begin
                            r_state    <= S_IDLE;
                            r_count    <= 8'd0;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_k     <= r_k + 8'd1;
                            r_state <= S_RD_ISSUE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SORT_CHECK_EN
    logic [7:0] r_prev;
    logic       r_order_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev      <= 8'd0;
            r_order_err <= 1'b0;
        end else if (r_state == S_WR_SIZE) begin
            r_order_err <= 1'b0;
        end else if ((r_state == S_OUT_HOLD) && out_ready) begin
            if ((r_k > 8'd1) && (r_out_data < r_prev))
                r_order_err <= 1'b1;
            r_prev <= r_out_data;
        end
    end

    assign order_err = r_order_err;
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_host.sv
// tb/tb_sort_host.sv - self-checking bench for sort_host (two instances: MAX_LEN 255 and 4)
module tb_sort_host;
    typedef logic [7:0] arr_t [256];

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic in_last = 1'b0;
    logic out_ready = 1'b1;

    logic [1:0] in_ready, out_valid, out_last, sort_start, mem_sel, mem_wren, busy, overflow, order_err;
    logic [1:0] sort_rdy, sort_done;
    logic [7:0] out_data [2];
    logic [7:0] mem_addr [2];
    logic [7:0] mem_wrdata [2];
    logic [7:0] mem_rddata [2];
    arr_t       mem [2];
    int         timer [2];

    int checks = 0;
    int passed = 0;
    logic bad_sort = 1'b0;
    logic rand_rdy = 1'b0;

    logic [7:0] stim [8];
    logic [7:0] raw [2][8];
    int         exp_n [2];
    logic [7:0] exp_data [2][256];
    logic       exp_lastb [2][256];
    logic       exp_dec [2][256];
    int         exp_wr [2];
    int         exp_rd [2];
    int         start_cnt [2];
    logic [7:0] act_log [2][64];
    int         act_n [2];

    logic       prev_stall [2];
    logic [7:0] prev_data [2];
    logic       prev_sel [2];
    logic       idle_due [2];
    logic       moe [2];
    logic       movf [2];
    int         in_cnt [2];

    always #5 clk = ~clk;

    sort_host u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
        .out_last(out_last[0]), .sort_rdy(sort_rdy[0]), .sort_start(sort_start[0]),
        .sort_done(sort_done[0]), .mem_sel(mem_sel[0]), .mem_addr(mem_addr[0]),
        .mem_wrdata(mem_wrdata[0]), .mem_wren(mem_wren[0]), .mem_rddata(mem_rddata[0]),
        .busy(busy[0]), .overflow(overflow[0]), .order_err(order_err[0])
    );

    sort_host #(.MAX_LEN(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
        .out_last(out_last[1]), .sort_rdy(sort_rdy[1]), .sort_start(sort_start[1]),
        .sort_done(sort_done[1]), .mem_sel(mem_sel[1]), .mem_addr(mem_addr[1]),
        .mem_wrdata(mem_wrdata[1]), .mem_wren(mem_wren[1]), .mem_rddata(mem_rddata[1]),
        .busy(busy[1]), .overflow(overflow[1]), .order_err(order_err[1])
    );

    function automatic int max_of(input int g);
        return (g == 0) ? 255 : 4;
    endfunction

    function automatic arr_t sorter_result(input arr_t m, input logic bad);
        arr_t r = m;
        int n = int'(m[0]);
        logic [7:0] t;
        if (!bad)
            for (int i = 1; i < n; i++)
                for (int j = i + 1; j <= n; j++)
                    if (r[j] < r[i]) begin
                        t = r[i]; r[i] = r[j]; r[j] = t;
                    end
        return r;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    endtask

    // Memory (host port when mem_sel=0) plus behavioural sorter
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sort_rdy  <= 2'b11;
            sort_done <= 2'b00;
            timer     <= '{0, 0};
        end else begin
            for (int g = 0; g < 2; g++) begin
                sort_done[g] <= 1'b0;
                if (!mem_sel[g]) begin
                    if (mem_wren[g]) mem[g][mem_addr[g]] <= mem_wrdata[g];
                    mem_rddata[g] <= mem[g][mem_addr[g]];
                end
                if (sort_start[g]) begin
                    sort_rdy[g] <= 1'b0;
                    timer[g]    <= 4;
                end else if (timer[g] != 0) begin
                    timer[g] <= timer[g] - 1;
                    if (timer[g] == 1) begin
                        mem[g]       <= sorter_result(mem[g], bad_sort);
                        sort_done[g] <= 1'b1;
                        sort_rdy[g]  <= 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle compare against the bench model
    always @(negedge clk) begin
        if (!rst) begin
            for (int g = 0; g < 2; g++) begin
                prev_stall[g] = 1'b0; prev_sel[g] = 1'b0; idle_due[g] = 1'b0;
                moe[g] = 1'b0; movf[g] = 1'b0; in_cnt[g] = 0;
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (idle_due[g]) check("busy_after_last", int'(busy[g]), 0);
                idle_due[g] = 1'b0;
                check("order_err", int'(order_err[g]), int'(moe[g]));
                check("overflow", int'(overflow[g]), int'(movf[g]));
                if (prev_stall[g]) begin
                    check("stall_valid", int'(out_valid[g]), 1);
                    check("stall_data", int'(out_data[g]), int'(prev_data[g]));
                end
                if (out_valid[g] && out_ready) begin
                    if (exp_rd[g] < exp_wr[g]) begin
                        check("out_data", int'(out_data[g]), int'(exp_data[g][exp_rd[g]]));
                        check("out_last", int'(out_last[g]), int'(exp_lastb[g][exp_rd[g]]));
                        if (exp_lastb[g][exp_rd[g]]) idle_due[g] = 1'b1;
`ifdef SORT_CHECK_EN
                        if (exp_dec[g][exp_rd[g]]) moe[g] = 1'b1;
`endif
                        exp_rd[g]++;
                    end else begin
                        check("extra_output", int'(out_valid[g]), 0);
                    end
                    if (act_n[g] < 64) begin
                        act_log[g][act_n[g]] = out_data[g];
                        act_n[g]++;
                    end
                end
                prev_stall[g] = out_valid[g] && !out_ready;
                prev_data[g]  = out_data[g];
                if (mem_sel[g] && !prev_sel[g]) begin
                    check("mem_len", int'(mem[g][0]), exp_n[g]);
                    for (int i = 0; i < exp_n[g]; i++)
                        check("mem_elem", int'(mem[g][i + 1]), int'(raw[g][i]));
                end
                prev_sel[g] = mem_sel[g];
                if (sort_start[g]) begin
                    start_cnt[g]++;
                    check("start_needs_rdy", int'(sort_rdy[g]), 1);
                end
                if (mem_wren[g] && !mem_sel[g] && (mem_addr[g] == 8'd0)) moe[g] = 1'b0;
                if (in_valid && in_ready[g]) begin
                    if (in_cnt[g] == 0) movf[g] = 1'b0;
                    in_cnt[g]++;
                    if (in_cnt[g] > max_of(g)) movf[g] = 1'b1;
                    if (in_last) in_cnt[g] = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic reset_chk();
        for (int g = 0; g < 2; g++) begin
            check("rst_in_ready", int'(in_ready[g]), 0);
            check("rst_out_valid", int'(out_valid[g]), 0);
            check("rst_out_last", int'(out_last[g]), 0);
            check("rst_out_data", int'(out_data[g]), 0);
            check("rst_sort_start", int'(sort_start[g]), 0);
            check("rst_mem_sel", int'(mem_sel[g]), 0);
            check("rst_mem_wren", int'(mem_wren[g]), 0);
            check("rst_mem_addr", int'(mem_addr[g]), 0);
            check("rst_mem_wrdata", int'(mem_wrdata[g]), 0);
            check("rst_busy", int'(busy[g]), 0);
            check("rst_overflow", int'(overflow[g]), 0);
            check("rst_order_err", int'(order_err[g]), 0);
        end
    endtask

    task automatic do_load(input int n);
        logic [7:0] seq [8];
        int m;
        int idx;
        logic ok;
        for (int g = 0; g < 2; g++) begin
            m = (n < max_of(g)) ? n : max_of(g);
            exp_n[g] = m;
            start_cnt[g] = 0;
            act_n[g] = 0;
            for (int i = 0; i < m; i++) raw[g][i] = stim[i];
            idx = 0;
            if (bad_sort) begin
                for (int i = 0; i < m; i++) seq[i] = raw[g][i];
            end else begin
                for (int v = 0; v < 256; v++)
                    for (int i = 0; i < m; i++)
                        if (int'(raw[g][i]) == v) begin
                            seq[idx] = raw[g][i];
                            idx++;
                        end
            end
            for (int i = 0; i < m; i++) begin
                exp_data[g][exp_wr[g]]  = seq[i];
                exp_lastb[g][exp_wr[g]] = (i == m - 1);
                exp_dec[g][exp_wr[g]]   = (i > 0) && (seq[i] < seq[i - 1]);
                exp_wr[g]++;
            end
        end
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = stim[i];
            in_last  = (i == n - 1);
            ok = 1'b0;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (in_ready == 2'b11) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) check("in_ready_timeout", int'(in_ready), 3);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (busy == 2'b00) break;
        end
        check("done_timeout", int'(busy), 0);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("all_out", exp_rd[g], exp_wr[g]);
            check("one_start", start_cnt[g], 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input int g, input string nm, input int n,
                       input int v0, input int v1, input int v2, input int v3, input int v4);
        int v [5];
        v = '{v0, v1, v2, v3, v4};
        check({nm, "_count"}, act_n[g], n);
        for (int i = 0; i < n && i < 5; i++) check(nm, int'(act_log[g][i]), v[i]);
    endtask

    initial begin
        exp_wr = '{0, 0};
        exp_rd = '{0, 0};
        act_n  = '{0, 0};
        exp_n  = '{0, 0};
        #1;
        reset_chk();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("in_ready_before_edge", int'(in_ready), 0);
        @(posedge clk);
        #1;
        check("in_ready_after_edge", int'(in_ready), 3);

        stim = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd7, 8'd0, 8'd0, 8'd0};
        do_load(5);
        wait_done();
        pin(0, "t1_out0", 5, 1, 3, 5, 7, 9);
        pin(1, "t1_out1", 4, 1, 3, 5, 9, 0);
        check("t1_len0", int'(mem[0][0]), 5);
        check("t1_len1", int'(mem[1][0]), 4);
        check("t1_ovf1", int'(overflow[1]), 1);

        stim = '{8'd42, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        do_load(1);
        wait_done();
        pin(0, "t2_out", 1, 42, 0, 0, 0, 0);
        check("t2_len", int'(mem[0][0]), 1);
        check("t2_ovf1_cleared", int'(overflow[1]), 0);

        rand_rdy = 1'b1;
        stim = '{8'd4, 8'd4, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0};
        do_load(4);
        wait_done();
        rand_rdy = 1'b0;
        pin(0, "t3_out0", 4, 0, 4, 4, 255, 0);
        pin(1, "t3_out1", 4, 0, 4, 4, 255, 0);
        check("t3_ovf1_at_max", int'(overflow[1]), 0);

        stim = '{8'd10, 8'd8, 8'd6, 8'd4, 8'd2, 8'd0, 8'd0, 8'd0};
        do_load(6);
        wait_done();
        pin(1, "t4_out1", 4, 4, 6, 8, 10, 0);
        check("t4_len1", int'(mem[1][0]), 4);
        check("t4_ovf1", int'(overflow[1]), 1);
        check("t4_ovf0", int'(overflow[0]), 0);

        bad_sort = 1'b1;
        stim = '{8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        do_load(2);
        wait_done();
        bad_sort = 1'b0;
        pin(0, "t5_out", 2, 2, 1, 0, 0, 0);
`ifdef SORT_CHECK_EN
        check("t5_order_err", int'(order_err[0]), 1);
`else
        check("t5_order_err", int'(order_err[0]), 0);
`endif
        stim = '{8'd8, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        do_load(2);
        wait_done();
        check("t6_order_err_cleared", int'(order_err[0]), 0);

        stim = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        do_load(3);
        begin
            logic seen;
            seen = 1'b0;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (mem_sel[0] && !sort_rdy[0]) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("reach_sorting", int'(seen), 1);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        reset_chk();
        exp_rd[0] = exp_wr[0];
        exp_rd[1] = exp_wr[1];
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_in_ready_before_edge", int'(in_ready), 0);
        @(posedge clk);
        #1;
        check("rel_in_ready_after_edge", int'(in_ready), 3);

        stim = '{8'd6, 8'd5, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        do_load(3);
        wait_done();
        pin(0, "t7_out0", 3, 4, 5, 6, 0, 0);
        pin(1, "t7_out1", 3, 4, 5, 6, 0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/sort_host.md
Name: sort_host

Overview:
- Host-side controller for the in-place selection sort engine.
- Accepts an input byte stream and writes it into the shared single-port 8-bit memory: length at address 0, elements at addresses 1..N.
- Hands memory ownership to the sorter and initiates it over the start/rdy/done handshake.
- After completion, reads the sorted array back and emits it as an output byte stream.

Parameters:
- MAX_LEN, 255, maximum element count stored (1..255); excess input bytes are dropped.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input byte valid.
- in_ready  out  1  input byte accepted when in_valid and in_ready are both 1.
- in_data  in  8  input element.
- in_last  in  1  marks the final element of an array.
- out_valid  out  1  sorted byte valid.
- out_ready  in  1  downstream accept.
- out_data  out  8  sorted element.
- out_last  out  1  final sorted element.
- sort_rdy  in  1  sorter idle / ready for start.
- sort_start  out  1  one-cycle start pulse to sorter.
- sort_done  in  1  sorter completion pulse (optional; may be tied 0).
- mem_sel  out  1  memory owner: 0 = this block, 1 = sorter; drives the external port mux.
- mem_addr  out  8  memory address.
- mem_wrdata  out  8  memory write data.
- mem_wren  out  1  memory write enable.
- mem_rddata  in  8  memory read data; synchronous read, valid 1 cycle after address.
- busy  out  1  high in any state other than IDLE.
- overflow  out  1  sticky: last load exceeded MAX_LEN; cleared on first accepted byte of the next load.
- order_err  out  1  see Optional Feature.

Behaviour:
- Reset (rst=0, async): state=IDLE, count=0, k=0.
  - Outputs during reset: in_ready=0, out_valid=0, out_last=0, out_data=0, sort_start=0, mem_sel=0, mem_wren=0, mem_addr=0, mem_wrdata=0, busy=0, overflow=0, order_err=0.
  - in_ready rises on the first clk edge after rst releases.
- Reset mid-operation aborts unconditionally: memory contents are undefined, no output byte is emitted, mem_sel returns to 0 immediately.
- States: IDLE, LOAD, WR_SIZE, ARM, WAIT_RDY, SORTING, RD_ISSUE, RD_WAIT, OUT_HOLD.
- IDLE/LOAD: in_ready=1, mem_sel=0.
  - On each handshake with count<MAX_LEN: same-cycle mem_wren=1, mem_addr=count+1, mem_wrdata=in_data; count increments.
  - With count==MAX_LEN: byte is accepted and dropped, overflow is set.
  - Handshake with in_last=1 -> WR_SIZE. Otherwise the first handshake moves IDLE -> LOAD.
  - N is always >=1 because in_last qualifies a data byte.
- WR_SIZE: in_ready=0, mem_wren=1, mem_addr=0, mem_wrdata=count (N). -> ARM.
- ARM: mem_sel=1 for at least 1 cycle, so the sorter's address-0 read is presented before start. -> WAIT_RDY.
- WAIT_RDY: mem_sel=1. When sort_rdy=1: sort_start=1 for exactly that cycle, cycle counter cleared. -> SORTING.
- SORTING: mem_sel=1, sort_start=0.
  - Completion = first cycle, at least 2 cycles after the start pulse, with sort_done=1 or sort_rdy=1.
  - On completion: mem_sel=0, k=1. -> RD_ISSUE.
- RD_ISSUE: mem_addr=k. -> RD_WAIT.
- RD_WAIT: latch mem_rddata into out_data. -> OUT_HOLD.
- OUT_HOLD: out_valid=1, out_data stable, out_last=(k==N).
  - On out_ready: if k==N -> IDLE (count=0); else k=k+1 -> RD_ISSUE.
  - Throughput: 1 byte per 3 cycles; backpressure holds the byte indefinitely.
- Arithmetic: all counters 8-bit. k never wraps (k<=N<=255). count saturates at MAX_LEN.
- in_valid during any non-LOAD/IDLE state is ignored (in_ready=0).

Optional Feature:
- Macro SORT_CHECK_EN.
  - Defined: during readback, an 8-bit prev register tracks the last emitted byte. If out_data < prev at an output handshake (k>1), order_err is set. order_err is sticky until the next WR_SIZE.
  - Undefined: order_err is tied 0 and no comparator or prev register is synthesized.

Test Plan:
- Load 5,3,9,1,7 (last on 7), behavioural sorter model:
  - Writes mem[1..5]=5,3,9,1,7 and mem[0]=5.
  - Single sort_start pulse while sort_rdy=1.
  - Output 1,3,5,7,9 with out_last only on 9.
- Single byte 42 with in_last -> mem[0]=1; output 42 with out_last=1; busy falls the cycle after the handshake.
- Load 4,4,0,255; out_ready toggled pseudo-randomly -> output exactly 0,4,4,255; out_data stable while stalled; no drop or duplicate.
- MAX_LEN=4, send 6 bytes (10,8,6,4,2,0) -> mem[0]=4, overflow=1, output 4,6,8,10.
- rst pulsed low during SORTING -> same cycle mem_sel=0, sort_start=0, out_valid=0; in_ready=1 after release; next load completes normally.
- SORT_CHECK_EN defined, sorter model leaves 2,1 unsorted -> order_err=1 after second output handshake and held until next WR_SIZE.
